dmem_port_arb: RTL and testbench

Responder end of the CPU-to-DMEM line interface in the two-core SMP. It accepts line read/write requests from cpu0 and cpu1 (u_addr/u_re/u_we/d_line) and serialises them onto the single shared d_mem port. It returns a per-CPU ready pulse and read line, replacing the shared dmem_rdy wire. It sits between the two cpu instances and d_mem, next to the coherence bus.

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 27 ++
 rtl/dmem_port_arb.sv | 131 +++++++++++++
 tb/tb_dmem_port_arb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and default widths for the CPU-to-DMEM port arbiter.
`default_nettype none

package dmem_arb_pkg;

  localparam int ADDR_W_DEF  = 11;
  localparam int LINE_W_DEF  = 64;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin picker, combinational grant, registered history.
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (accept) last_grant <= grant[1];
  end

endmodule

`default_nettype wire

// File: rtl/dmem_port_arb.sv
// dmem_port_arb: serialises cpu0/cpu1 line accesses onto the single d_mem port,
// returning a per-CPU completion pulse and read line, with a bounded wait on mem_rdy.
`default_nettype none

module dmem_port_arb
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu0_u_addr,
  input  logic              cpu0_u_re,
  input  logic              cpu0_u_we,
  input  logic [LINE_W-1:0] cpu0_d_line,
  output logic              cpu0_u_rdy,
  output logic [LINE_W-1:0] cpu0_u_rd_data,
  input  logic [ADDR_W-1:0] cpu1_u_addr,
  input  logic              cpu1_u_re,
  input  logic              cpu1_u_we,
  input  logic [LINE_W-1:0] cpu1_d_line,
  output logic              cpu1_u_rdy,
  output logic [LINE_W-1:0] cpu1_u_rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rd_data,
  input  logic              mem_rdy,
  output logic              busy,
  output logic              active_cpu,
  output logic              bus_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state;
  state_e            state_nxt;
  op_e               op;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic              accept;
  logic              grant_cpu;
  logic              sel_re;
  logic              sel_we;
  logic              timeout_hit;
  logic              issue_done;
  logic [LINE_W-1:0] rd_next;

  assign req         = {cpu1_u_re | cpu1_u_we, cpu0_u_re | cpu0_u_we};
  assign accept      = (state == IDLE) && (req != 2'b00);
  assign grant_cpu   = grant[1];
  assign sel_re      = grant_cpu ? cpu1_u_re : cpu0_u_re;
  assign sel_we      = grant_cpu ? cpu1_u_we : cpu0_u_we;
  assign timeout_hit = (state == ISSUE) && !mem_rdy && (cnt == CNT_LAST);
  assign issue_done  = (state == ISSUE) && (mem_rdy || timeout_hit);
  // An aborted read returns an all-zero line.
  assign rd_next     = mem_rdy ? mem_rd_data : '0;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .accept (accept),
    .grant  (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (issue_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    cpu0_u_rdy = (state == RESP) && !active_cpu;
    cpu1_u_rdy = (state == RESP) && active_cpu;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      op             <= OP_RD;
      active_cpu     <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_re         <= 1'b0;
      mem_we         <= 1'b0;
      bus_err        <= 1'b0;
      cpu0_u_rd_data <= '0;
      cpu1_u_rd_data <= '0;
    end else if (accept) begin
      cnt        <= '0;
      active_cpu <= grant_cpu;
      mem_addr   <= grant_cpu ? cpu1_u_addr : cpu0_u_addr;
      mem_wdata  <= grant_cpu ? cpu1_d_line : cpu0_d_line;
      // Read and write together from one CPU is a write.
      mem_we     <= sel_we;
      mem_re     <= sel_re & ~sel_we;
      op         <= sel_we ? OP_WR : OP_RD;
    end else if (state == ISSUE) begin
      if (issue_done) begin
        mem_re <= 1'b0;
        mem_we <= 1'b0;
        if (timeout_hit) bus_err <= 1'b1;
        if (op == OP_RD) begin
          if (active_cpu) cpu1_u_rd_data <= rd_next;
          else            cpu0_u_rd_data <= rd_next;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arb.sv
// tb_dmem_port_arb: directed and randomized accesses checked against a transaction-level model.
`default_nettype none

module tb_dmem_port_arb;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] c_addr [2];
  logic        c_re   [2];
  logic        c_we   [2];
  logic [63:0] c_line [2];
  logic        rdy    [2];
  logic [63:0] rd     [2];
  logic [10:0] mem_addr;
  logic        mem_re, mem_we, mem_rdy, busy, active_cpu, bus_err;
  logic [63:0] mem_wdata, mem_rd_data;

  // Reference model state
  bit          pend   [2];
  bit          m_wr   [2];
  logic [10:0] m_addr [2];
  logic [63:0] m_line [2];
  logic [63:0] rd_exp [2];
  bit          err_exp;
  bit          last_g;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_port_arb #(.ADDR_W(11), .LINE_W(64), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu0_u_addr    (c_addr[0]),
    .cpu0_u_re      (c_re[0]),
    .cpu0_u_we      (c_we[0]),
    .cpu0_d_line    (c_line[0]),
    .cpu0_u_rdy     (rdy[0]),
    .cpu0_u_rd_data (rd[0]),
    .cpu1_u_addr    (c_addr[1]),
    .cpu1_u_re      (c_re[1]),
    .cpu1_u_we      (c_we[1]),
    .cpu1_d_line    (c_line[1]),
    .cpu1_u_rdy     (rdy[1]),
    .cpu1_u_rd_data (rd[1]),
    .mem_addr       (mem_addr),
    .mem_re         (mem_re),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_rd_data    (mem_rd_data),
    .mem_rdy        (mem_rdy),
    .busy           (busy),
    .active_cpu     (active_cpu),
    .bus_err        (bus_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 read, 1 write, 2 read+write together
  task automatic set_req(input int c, input logic [10:0] a, input logic [63:0] l, input int kind);
    c_addr[c] = a;
    c_line[c] = l;
    c_re[c]   = (kind != 1);
    c_we[c]   = (kind != 0);
    pend[c]   = 1'b1;
    m_wr[c]   = (kind != 0);
    m_addr[c] = a;
    m_line[c] = l;
  endtask

  // Entered at the negedge where the request is visible in IDLE; returns at the
  // negedge of the IDLE cycle that follows the completion pulse.
  task automatic run_access(input int lat, input logic [63:0] rdata, input bit drop_early);
    int w;
    int k;
    bit timed_out;
    if (pend[0] && pend[1]) w = last_g ? 0 : 1;
    else                    w = pend[1] ? 1 : 0;
    last_g = (w == 1);
    timed_out = 1'b0;
    k = 1;
    @(negedge clk);
    check("busy_issue", busy, 1);
    check("owner", active_cpu, w);
    forever begin
      mem_rdy     = 1'b0;
      mem_rd_data = {$urandom, $urandom};
      check("mem_we_hold", mem_we, m_wr[w]);
      check("mem_re_hold", mem_re, !m_wr[w]);
      check("mem_addr_hold", mem_addr, m_addr[w]);
      if (m_wr[w]) check("mem_wdata_hold", mem_wdata, m_line[w]);
      check("no_rdy_issue", {rdy[1], rdy[0]}, 0);
      if (drop_early && k == 1) begin
        c_re[w] = 1'b0;
        c_we[w] = 1'b0;
      end
      if (k == lat) begin
        mem_rdy     = 1'b1;
        mem_rd_data = rdata;
        break;
      end
      if (k == TO) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    if (timed_out) err_exp = 1'b1;
    if (!m_wr[w]) rd_exp[w] = timed_out ? 64'd0 : rdata;
    check("rdy_owner", rdy[w], 1);
    check("rdy_other", rdy[1-w], 0);
    check("strobes_resp", {mem_re, mem_we}, 0);
    check("busy_resp", busy, 1);
    check("rd_data0", rd[0], rd_exp[0]);
    check("rd_data1", rd[1], rd_exp[1]);
    check("bus_err", bus_err, err_exp);
    c_re[w] = 1'b0;
    c_we[w] = 1'b0;
    pend[w] = 1'b0;
    // mem_rdy outside ISSUE must be ignored
    mem_rdy     = 1'b1;
    mem_rd_data = {$urandom, $urandom};
    @(negedge clk);
    check("rdy_idle", {rdy[1], rdy[0]}, 0);
    check("busy_idle", busy, 0);
    check("rd_hold0", rd[0], rd_exp[0]);
    check("rd_hold1", rd[1], rd_exp[1]);
    check("bus_err_idle", bus_err, err_exp);
  endtask

  task automatic drain(input int lat);
    while (pend[0] || pend[1]) run_access(lat, {$urandom, $urandom}, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    mem_rdy = 1'b0;
    mem_rd_data = '0;
    for (int i = 0; i < 2; i++) begin
      c_addr[i] = '0; c_line[i] = '0; c_re[i] = 1'b0; c_we[i] = 1'b0;
      pend[i] = 1'b0; rd_exp[i] = '0; m_wr[i] = 1'b0; m_addr[i] = '0; m_line[i] = '0;
    end
    err_exp = 1'b0;
    last_g  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_strobes", {mem_re, mem_we, busy, active_cpu, bus_err}, 0);
    check("rst_rdy", {rdy[1], rdy[0]}, 0);
    check("rst_rd0", rd[0], 0);
    check("rst_rd1", rd[1], 0);
    check("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    set_req(0, 11'h155, 64'h0, 0);
    run_access(2, 64'hDEADBEEF_CAFEF00D, 1'b0);
    set_req(1, 11'h7FF, 64'h0123456789ABCDEF, 1);
    run_access(4, 64'h0, 1'b0);

    // Simultaneous requests, twice: cpu0 wins both times
    set_req(0, 11'h0A1, 64'h1111, 0);
    set_req(1, 11'h0B2, 64'h2222, 1);
    run_access(1, 64'hAAAA_5555_AAAA_5555, 1'b0);
    run_access(3, 64'h0, 1'b0);
    set_req(0, 11'h0C3, 64'h3333, 1);
    set_req(1, 11'h0D4, 64'h4444, 0);
    run_access(2, 64'h0, 1'b0);
    run_access(1, 64'h7777_8888_9999_0000, 1'b0);

    set_req(0, 11'h010, 64'hFEED_FACE_0000_0001, 2);
    run_access(1, 64'h0, 1'b0);

    // Early-dropped request still completes
    set_req(1, 11'h020, 64'h0, 0);
    run_access(3, 64'h5A5A_5A5A_5A5A_5A5A, 1'b1);

    // Timeout on a read, then a normal access with bus_err still sticky
    set_req(0, 11'h3FF, 64'h0, 0);
    run_access(100, 64'h0, 1'b0);
    set_req(1, 11'h001, 64'h0, 0);
    run_access(1, 64'hC0DE_C0DE_C0DE_C0DE, 1'b0);

    for (int r = 0; r < 40; r++) begin
      int who;
      int lat;
      who = $urandom_range(1, 3);
      for (int c = 0; c < 2; c++)
        if (who[c]) set_req(c, 11'($urandom), {$urandom, $urandom}, $urandom_range(0, 2));
      lat = ($urandom_range(0, 9) == 0) ? 50 : $urandom_range(1, 6);
      drain(lat);
    end

    // Reset in the middle of an access
    set_req(0, 11'h155, 64'h0, 0);
    @(negedge clk);
    check("busy_pre_rst", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_strobe", {mem_re, mem_we}, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_rdy", {rdy[1], rdy[0]}, 0);
    check("rst_async_err", bus_err, 0);
    c_re[0] = 1'b0; c_we[0] = 1'b0; pend[0] = 1'b0;
    mem_rdy = 1'b0;
    rd_exp[0] = '0; rd_exp[1] = '0; err_exp = 1'b0; last_g = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", busy, 0);
    set_req(0, 11'h2AA, 64'h0, 0);
    set_req(1, 11'h155, 64'h9, 1);
    drain(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
